keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end for the door-lock controller. Scans a 4-row × 3-column keypad (0–9, `*`, `#`) and debounces the contacts. Produces the 12-bit one-hot key code that the lock FSM consumes, held for as long as the key is physically pressed and all-zero when released. This block is the producing end of the `inputChar` interface.

## Interface
- `CLK_DIV`, default 50000: clk cycles per scan tick; must be ≥ 4.
- `DEBOUNCE_TICKS`, default 4: consecutive stable ticks required for press and for release; must be ≥ 1.
- `REPEAT_TICKS`, default 250: ticks a key is held before auto-repeat. Used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `row_n`  out  4  row drive, active-low, exactly one row low at any time.
- `col_n`  in  3  column sense, active-low (externally pulled up), asynchronous to `clk`.
- `key_onehot`  out  12  one-hot key code, 0 when no key is held. Bit 0–9 = digits 0–9, bit 10 = `*`, bit 11 = `#`.
- `key_valid`  out  1  equals `|key_onehot`.
- `key_strobe`  out  1  one-clk pulse when `key_onehot` goes from 0 to non-zero.

## Operation
- Key map (row, col):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: `*`, 0, `#`
- `col_n` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick generator: counter 0..CLK_DIV-1. `tick` is asserted when the count equals CLK_DIV-1, then the counter wraps to 0.
- "Single" means exactly one synced column is low. Zero low columns, or two or more, is "none/invalid".
- FSM states:
  - **SCAN**: on each tick, sample columns.
    - Single low column: capture (row_idx, col), set stable_cnt = 1, hold the row. Go to DEBOUNCE, or directly to HELD if DEBOUNCE_TICKS = 1.
    - Otherwise: advance row_idx mod 4 and drive the next row low.
  - **DEBOUNCE**: on each tick:
    - Same single column still low: stable_cnt++. When stable_cnt reaches DEBOUNCE_TICKS, go to HELD; set `key_onehot` to the mapped code and pulse `key_strobe` on that same edge.
    - Anything else: go to SCAN and advance the row.
  - **HELD**: row stays fixed, output is held. On each tick:
    - Captured column high: release_cnt++.
    - Captured column low: release_cnt = 0.
    - When release_cnt reaches DEBOUNCE_TICKS: clear `key_onehot`, go to SCAN, advance the row.
    - Other columns going low while HELD are ignored, and no other key is reported until release.
- Two keys in the same row are invalid and never reported. Keys in different rows resolve to whichever row is scanned first.
- Counters saturate at their thresholds and never wrap.

## Timing
- Reset values: `row_n` = 4'b1110, `key_onehot` = 0, `key_valid` = 0, `key_strobe` = 0. The FSM is in SCAN with row_idx, tick counter, stable_cnt and release_cnt all 0.
- Reset takes effect on the next edge from any state. A held key must then be re-debounced from SCAN, with a new strobe.
- Row settle time: a row changes on a tick and is sampled on the next tick, which gives CLK_DIV−2 cycles of settle after sync.
- Press latency, from a stable press to `key_onehot` set: ≤ 3 + (3 + DEBOUNCE_TICKS)·CLK_DIV clk cycles.
- Release latency: ≤ 2 + (DEBOUNCE_TICKS + 1)·CLK_DIV clk cycles.
- All outputs are registered. `key_strobe` is high for exactly 1 clk per report.
- `key_onehot` never changes directly from one non-zero code to another; it passes through 0 for at least one tick.

## Configuration
- `KEYPAD_REPEAT_EN` defined: HELD counts ticks since entry.
  - At REPEAT_TICKS, `key_onehot` goes to 0 for 2 ticks, then reasserts the same code with a new `key_strobe`. This cycle repeats every REPEAT_TICKS for as long as the key is held.
  - Release detection continues throughout, including during the gap.
  - The gap guarantees the consumer sees a release between repeats.
- `KEYPAD_REPEAT_EN` undefined: exactly one report per press, and `REPEAT_TICKS` is unused.

## Test plan
Bench uses CLK_DIV = 4, DEBOUNCE_TICKS = 3, and a keypad model that shorts row to column with 1-cycle delay.
- Press `5` (r1, c1) stable → `key_onehot` = 12'h020 within 27 clk, a single 1-clk `key_strobe`, `key_valid` = 1. Release → 0 within 18 clk.
- Press `#` with bounce toggling every tick for 2 ticks, then stable → exactly one strobe, `key_onehot` = 12'h800. No output during the bounce.
- Press `1` and `2` simultaneously (same row) for 100 clk → `key_onehot` stays 0 and no strobe.
- Hold `0` until reported, then also press `*` → output stays 12'h001. Release both → 0. Press `*` → 12'h400.
- Assert `reset` for 1 clk while HELD on `9` → next edge: `key_onehot` = 0, `row_n` = 4'b1110. Key still held → re-reported 12'h200 with a new strobe.
- With `KEYPAD_REPEAT_EN`, REPEAT_TICKS = 10, hold `7` for 30 ticks → three strobes total, `key_onehot` = 12'h080 each time, with 2-tick zero gaps between them.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4-row x 3-column matrix keypad, debounces presses
// and releases, and reports the held key as a 12-bit one-hot code.
// Optional auto-repeat while a key stays held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 250
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  row_n,
    input  logic [2:0]  col_n,
    output logic [11:0] key_onehot,
    output logic        key_valid,
    output logic        key_strobe
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (CLK_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 3) begin : g_param_check
        $error("keypad_scanner: illegal parameter values");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    logic [2:0]    col_s1, col_s2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    state_t        state;
    logic [1:0]    row_idx, row_next, cap_col, col_idx;
    logic [CW-1:0] stable_cnt, release_cnt;
    logic          col_single, cap_high;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_ONE = RW'(1);
    logic [RW-1:0] rep_cnt;
    logic [1:0]    gap_cnt;
`endif

    // Map (row, col) to the one-hot bit: digits 0-9 on bits 0-9, '*' bit 10, '#' bit 11.
    function automatic logic [11:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] idx;
        if (r == 2'd3) begin
            case (c)
                2'd0:    idx = 4'd10;
                2'd1:    idx = 4'd0;
                default: idx = 4'd11;
            endcase
        end else begin
            idx = 4'(r) * 4'd3 + 4'(c) + 4'd1;
        end
        return 12'd1 << idx;
    endfunction

    // Active-low drive pattern with only the selected row pulled low.
    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    assign tick     = (tick_cnt == TICK_MAX);
    assign row_next = row_idx + 2'd1;
    assign cap_high = col_s2[cap_col];

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1 <= 3'b111;
            col_s2 <= 3'b111;
        end else begin
            col_s1 <= col_n;
            col_s2 <= col_s1;
        end
    end

    // Scan tick generator: one tick every CLK_DIV clocks.
    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TW'(1);
    end

    // Decode "exactly one column low" and which one.
    always_comb begin
        col_single = 1'b1;
        col_idx    = 2'd0;
        case (col_s2)
            3'b110:  col_idx = 2'd0;
            3'b101:  col_idx = 2'd1;
            3'b011:  col_idx = 2'd2;
            default: col_single = 1'b0;
        endcase
    end

    // Scan / debounce / hold state machine; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN;
            row_idx     <= 2'd0;
            row_n       <= 4'b1110;
            cap_col     <= 2'd0;
            stable_cnt  <= '0;
            release_cnt <= '0;
            key_onehot  <= '0;
            key_valid   <= 1'b0;
            key_strobe  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            gap_cnt     <= 2'd0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (tick) begin
`ifdef KEYPAD_REPEAT_EN
                if (state != HELD) begin
                    rep_cnt <= '0;
                    gap_cnt <= 2'd0;
                end
`endif
                case (state)
                    SCAN: begin
                        if (col_single) begin
                            cap_col     <= col_idx;
                            stable_cnt  <= CNT_ONE;
                            release_cnt <= '0;
                            if (DEBOUNCE_TICKS == 1) begin
                                state      <= HELD;
                                key_onehot <= key_code(row_idx, col_idx);
                                key_valid  <= 1'b1;
                                key_strobe <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            row_idx <= row_next;
                            row_n   <= row_drive(row_next);
                        end
                    end
                    DEBOUNCE: begin
                        if (col_single && col_idx == cap_col) begin
                            stable_cnt <= stable_cnt + CNT_ONE;
                            if (stable_cnt + CNT_ONE == DB_MAX) begin
                                state      <= HELD;
                                key_onehot <= key_code(row_idx, cap_col);
                                key_valid  <= 1'b1;
                                key_strobe <= 1'b1;
                            end
                        end else begin
                            state      <= SCAN;
                            stable_cnt <= '0;
                            row_idx    <= row_next;
                            row_n      <= row_drive(row_next);
                        end
                    end
                    HELD: begin
                        // Only the captured column matters; other keys are ignored until release.
                        if (cap_high && release_cnt + CNT_ONE == DB_MAX) begin
                            state       <= SCAN;
                            key_onehot  <= '0;
                            key_valid   <= 1'b0;
                            release_cnt <= '0;
                            stable_cnt  <= '0;
                            row_idx     <= row_next;
                            row_n       <= row_drive(row_next);
                        end else begin
                            release_cnt <= cap_high ? release_cnt + CNT_ONE : '0;
`ifdef KEYPAD_REPEAT_EN
                            // Repeat: drop the code for two ticks so the consumer sees a release.
                            if (rep_cnt + REP_ONE == REP_MAX) begin
                                rep_cnt    <= '0;
                                gap_cnt    <= 2'd2;
                                key_onehot <= '0;
                                key_valid  <= 1'b0;
                            end else begin
                                rep_cnt <= rep_cnt + REP_ONE;
                                if (gap_cnt != 2'd0) begin
                                    gap_cnt <= gap_cnt - 2'd1;
                                    if (gap_cnt == 2'd1) begin
                                        key_onehot <= key_code(row_idx, cap_col);
                                        key_valid  <= 1'b1;
                                        key_strobe <= 1'b1;
                                    end
                                end
                            end
`endif
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model (row-to-column short, one clock of delay),
// per-cycle output rules plus press/release latency windows for random and
// directed key sequences.
module tb_keypad_scanner;

    localparam int CLK_DIV     = 4;
    localparam int DB          = 3;
    localparam int PRESS_MAX   = 3 + (3 + DB) * CLK_DIV;
    localparam int RELEASE_MAX = 2 + (DB + 1) * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [2:0]  col_n = 3'b111;
    logic [11:0] key_onehot;
    logic        key_valid;
    logic        key_strobe;

    int          checks = 0;
    int          failures = 0;
    int          strobes = 0;
    bit          mon_en = 1'b0;
    bit          pressed [12];
    logic [11:0] allowed = '0;
    logic [11:0] prev_onehot = '0;

    keypad_scanner #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE_TICKS(DB),
        .REPEAT_TICKS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row_n(row_n),
        .col_n(col_n),
        .key_onehot(key_onehot),
        .key_valid(key_valid),
        .key_strobe(key_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int krow(input int k);
        if (k >= 1 && k <= 9) return (k - 1) / 3;
        return 3;
    endfunction

    function automatic int kcol(input int k);
        if (k >= 1 && k <= 9) return (k - 1) % 3;
        if (k == 0) return 1;
        if (k == 10) return 0;
        return 2;
    endfunction

    function automatic logic [11:0] code_of(input int k);
        logic [11:0] c = 12'h001;
        return c << k;
    endfunction

    function automatic logic [2:0] cols_for(input logic [3:0] rs);
        logic [2:0] c = 3'b111;
        for (int k = 0; k < 12; k++)
            if (pressed[k] && !rs[krow(k)]) c[kcol(k)] = 1'b0;
        return c;
    endfunction

    // Keypad: a pressed key shorts its row to its column, seen one clock later.
    always @(posedge clk) begin
        logic [3:0] rs;
        rs = row_n;
        #1;
        col_n = cols_for(rs);
    end

    // Per-cycle output rules.
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_is_or", key_valid, |key_onehot);
            check("strobe_on_rise", key_strobe, (key_onehot != 0 && prev_onehot == 0));
            check("one_row_low", $countones(~row_n), 1);
            check("code_allowed", key_onehot, (key_onehot == 0) ? 12'h000 : allowed);
        end
        if (key_strobe) strobes++;
        prev_onehot = key_onehot;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_code(input string name, input logic [11:0] exp, input int limit);
        int n = 0;
        while (key_onehot !== exp && n < limit) begin
            step(1);
            n++;
        end
        check(name, key_onehot, exp);
    endtask

    task automatic key_cycle(input string name, input int k, input logic [11:0] exp, input int hold);
        int s0;
        allowed = exp;
        s0 = strobes;
        pressed[k] = 1'b1;
        wait_code({name, "_press"}, exp, PRESS_MAX);
        check({name, "_valid"}, key_valid, 1);
        for (int i = 0; i < hold; i++) begin
            step(1);
            check({name, "_hold"}, key_onehot, exp);
        end
        pressed[k] = 1'b0;
        wait_code({name, "_release"}, 12'h000, RELEASE_MAX);
        check({name, "_strobes"}, strobes - s0, 1);
        step(3);
    endtask

    initial begin
        int s0;
        int run;
        for (int k = 0; k < 12; k++) pressed[k] = 1'b0;
        reset = 1'b1;
        step(3);
        check("rst_row_n", row_n, 4'b1110);
        check("rst_onehot", key_onehot, 0);
        check("rst_valid", key_valid, 0);
        check("rst_strobe", key_strobe, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        step(2);

`ifdef KEYPAD_REPEAT_EN
        allowed = 12'h080;
        pressed[7] = 1'b1;
        wait_code("rep_first", 12'h080, PRESS_MAX);
        s0 = strobes;
        run = 0;
        for (int i = 0; i < 30 * CLK_DIV; i++) begin
            step(1);
            if (key_onehot == 0) run++;
            else begin
                if (run != 0) check("rep_gap_len", run, 2 * CLK_DIV);
                run = 0;
            end
        end
        check("rep_strobes", strobes - s0 + 1, 3);
        pressed[7] = 1'b0;
        step(60);
        check("rep_released", key_onehot, 0);
`else
        // Digit 5, stable press.
        key_cycle("k5", 5, 12'h020, 20);

        // '#' bouncing for two ticks before settling.
        allowed = 12'h800;
        s0 = strobes;
        for (int i = 0; i < 2; i++) begin
            pressed[11] = 1'b1;
            step(CLK_DIV);
            pressed[11] = 1'b0;
            step(CLK_DIV);
        end
        check("bounce_quiet_code", key_onehot, 0);
        check("bounce_quiet_strobe", strobes - s0, 0);
        key_cycle("hash", 11, 12'h800, 10);

        // '1' and '2' together share a row: never reported.
        allowed = 12'h000;
        s0 = strobes;
        pressed[1] = 1'b1;
        pressed[2] = 1'b1;
        step(100);
        check("same_row_code", key_onehot, 0);
        check("same_row_strobe", strobes - s0, 0);
        pressed[1] = 1'b0;
        pressed[2] = 1'b0;
        step(8);

        // Hold '0', then add '*': the held report must not change.
        allowed = 12'h001;
        s0 = strobes;
        pressed[0] = 1'b1;
        wait_code("zero_press", 12'h001, PRESS_MAX);
        pressed[10] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            check("zero_star_ignored", key_onehot, 12'h001);
        end
        pressed[0] = 1'b0;
        pressed[10] = 1'b0;
        wait_code("zero_release", 12'h000, RELEASE_MAX);
        check("zero_strobes", strobes - s0, 1);
        step(3);
        key_cycle("star", 10, 12'h400, 12);

        // Reset while '9' is held: cleared immediately, then re-reported.
        allowed = 12'h200;
        pressed[9] = 1'b1;
        wait_code("nine_press", 12'h200, PRESS_MAX);
        s0 = strobes;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("nine_rst_code", key_onehot, 0);
        check("nine_rst_row", row_n, 4'b1110);
        check("nine_rst_valid", key_valid, 0);
        wait_code("nine_repress", 12'h200, PRESS_MAX);
        check("nine_new_strobe", strobes - s0, 1);
        pressed[9] = 1'b0;
        wait_code("nine_release", 12'h000, RELEASE_MAX);
        step(3);

        // Random single keys with random hold and idle times.
        for (int n = 0; n < 12; n++) begin
            int k;
            k = int'($urandom_range(0, 11));
            key_cycle("rand", k, code_of(k), int'($urandom_range(0, 30)));
            step(int'($urandom_range(0, 12)));
        end
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
